// File: rtl/pipelined_control_unit_if.sv
// Handshake and control-word bundle between the fetch stage, the
// pipelined control unit and the execute/memory datapath.
// Optional macro PCU_ILLEGAL_TRAP_EN adds the `illegal` flag.
interface pipelined_control_unit_if #(
   parameter int OPCODE_W   = 6,
   parameter int ALU_CTRL_W = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [OPCODE_W-1:0]   opcode;
   logic                  out_valid;
   logic                  out_ready;
   logic [ALU_CTRL_W-1:0] alu_control;
   logic [1:0]            imm_src;
   logic [1:0]            mem_to_reg;
   logic                  mem_write;
   logic                  reg_write;
   logic                  pc_src;
   logic                  alu_src;
`ifdef PCU_ILLEGAL_TRAP_EN
   logic                  illegal;

   modport master (
      output in_valid, opcode, out_ready,
      input  in_ready, out_valid, alu_control, imm_src, mem_to_reg,
             mem_write, reg_write, pc_src, alu_src, illegal
   );

   modport slave (
      input  in_valid, opcode, out_ready,
      output in_ready, out_valid, alu_control, imm_src, mem_to_reg,
             mem_write, reg_write, pc_src, alu_src, illegal
   );
`else
   modport master (
      output in_valid, opcode, out_ready,
      input  in_ready, out_valid, alu_control, imm_src, mem_to_reg,
             mem_write, reg_write, pc_src, alu_src
   );

   modport slave (
      input  in_valid, opcode, out_ready,
      output in_ready, out_valid, alu_control, imm_src, mem_to_reg,
             mem_write, reg_write, pc_src, alu_src
   );
`endif
endinterface

// File: rtl/pipelined_control_unit.sv
// Registered opcode decoder with valid/ready handshakes on both sides.
// MUL/MULI hold the unit for MUL_CYCLES cycles; flush drops whatever is in
// flight. Optional macro PCU_ILLEGAL_TRAP_EN adds a sticky `illegal` flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | can accept an opcode when the output slot is free/draining
//   MUL_WAIT | multiply in progress, counter running down to zero
module pipelined_control_unit #(
   parameter int OPCODE_W   = 6,
   parameter int ALU_CTRL_W = 5,
   parameter int MUL_CYCLES = 3
) (
   input logic clk,
   input logic rst,
   input logic flush,
   pipelined_control_unit_if.slave bus
);

   typedef enum logic [0:0] {IDLE, MUL_WAIT} state_t;

   typedef struct packed {
      logic [ALU_CTRL_W-1:0] alu_control;
      logic [1:0]            imm_src;
      logic [1:0]            mem_to_reg;
      logic                  mem_write;
      logic                  reg_write;
      logic                  pc_src;
      logic                  alu_src;
   } ctrl_t;

   // A single-cycle multiply needs no wait state at all.
   localparam bit MUL_SKIP = (MUL_CYCLES == 1);
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   ctrl_t      word;
   ctrl_t      pend;
   logic       out_valid_q;
   ctrl_t      dec;
   logic       legal;
   logic       is_mul;
   logic [5:0] op;
   logic       upper_zero;
   logic       in_ready_c;
   logic       accept;
   logic       consume;

   assign op         = bus.opcode[5:0];
   assign upper_zero = ((bus.opcode >> 6) == '0);

   // Legality check and field decode of the presented opcode.
   always_comb begin
      legal = 1'b0;
      case (op)
         6'b000000, 6'b000001, 6'b001001, 6'b000010, 6'b001010,
         6'b000011, 6'b001011, 6'b000100, 6'b001100,
         6'b010001, 6'b011001, 6'b010010, 6'b011010, 6'b010011, 6'b010100,
         6'b101001, 6'b101010, 6'b101011,
         6'b111000, 6'b111001, 6'b111010, 6'b111011,
         6'b111100, 6'b111101, 6'b111110: legal = upper_zero;
         default:                         legal = 1'b0;
      endcase

      is_mul = legal && (op[5:4] == 2'b00) && (op[2:0] == 3'b011);

      dec = '0;
      if (legal) begin
         dec.alu_control = ALU_CTRL_W'({op[5:4], op[2:0]});
         // Immediate, memory and jump forms carry their format in the group bits.
         dec.imm_src     = (op[3] || op[5]) ? op[5:4] : 2'b00;
         dec.alu_src     = op[3] || op[5];
         if ((op[5:4] == 2'b00) && (op[2:0] == 3'b100))
            dec.mem_to_reg = 2'b10;
         else if (op == 6'b101001)
            dec.mem_to_reg = 2'b01;
         dec.mem_write   = (op == 6'b101011);
         dec.reg_write   = ((op[5:4] == 2'b00) && (op != 6'b000000)) ||
                           (op[5:4] == 2'b01) ||
                           (op == 6'b101001) || (op == 6'b101010);
         dec.pc_src      = (op[5:4] == 2'b11);
      end
   end

   assign in_ready_c = !rst && (state == IDLE) && (!out_valid_q || bus.out_ready) && !flush;
   assign accept     = bus.in_valid && in_ready_c;
   assign consume    = out_valid_q && bus.out_ready;

   // Control FSM, multiply counter and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         word        <= '0;
         pend        <= '0;
         out_valid_q <= 1'b0;
`ifdef PCU_ILLEGAL_TRAP_EN
         bus.illegal <= 1'b0;
`endif
      end else if (flush) begin
         state       <= IDLE;
         cnt         <= '0;
         word        <= '0;
         out_valid_q <= 1'b0;
`ifdef PCU_ILLEGAL_TRAP_EN
         bus.illegal <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
`ifdef PCU_ILLEGAL_TRAP_EN
                  bus.illegal <= !legal;
`endif
                  if (is_mul && !MUL_SKIP) begin
                     // Acceptance implies the old word drains this edge.
                     pend        <= dec;
                     cnt         <= MUL_LOAD;
                     state       <= MUL_WAIT;
                     word        <= '0;
                     out_valid_q <= 1'b0;
                  end else begin
                     word        <= dec;
                     out_valid_q <= 1'b1;
                  end
               end else if (consume) begin
                  word        <= '0;
                  out_valid_q <= 1'b0;
               end
            end
            MUL_WAIT: begin
               if (cnt == 4'd0) begin
                  word        <= pend;
                  out_valid_q <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.alu_control = word.alu_control;
   assign bus.imm_src     = word.imm_src;
   assign bus.mem_to_reg  = word.mem_to_reg;
   assign bus.mem_write   = word.mem_write;
   assign bus.reg_write   = word.reg_write;
   assign bus.pc_src      = word.pc_src;
   assign bus.alu_src     = word.alu_src;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios with literal
// expectations, then random traffic checked every cycle against a
// transaction-level model (opcode table + multiply countdown).
module tb_pipelined_control_unit;

   localparam int MUL_CYCLES = 3;

   logic clk;
   logic rst;
   logic flush;

   pipelined_control_unit_if #(.OPCODE_W(6), .ALU_CTRL_W(5)) bus ();

   pipelined_control_unit #(
      .OPCODE_W(6), .ALU_CTRL_W(5), .MUL_CYCLES(MUL_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [5:0] LEGAL [25] = '{
      6'o00, 6'o01, 6'o11, 6'o02, 6'o12, 6'o03, 6'o13, 6'o04, 6'o14,
      6'o21, 6'o31, 6'o22, 6'o32, 6'o23, 6'o24,
      6'o51, 6'o52, 6'o53,
      6'o70, 6'o71, 6'o72, 6'o73, 6'o74, 6'o75, 6'o76
   };

   // Model state: the visible output slot plus cycles left on a multiply.
   logic        m_valid;
   logic [12:0] m_word;
   int          m_busy;
   logic [12:0] m_pend;
   logic        m_illegal;

   function automatic bit is_legal(input logic [5:0] op);
      for (int i = 0; i < 25; i++)
         if (LEGAL[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Word layout: {alu_control[4:0], imm_src, mem_to_reg, mem_write, reg_write, pc_src, alu_src}
   function automatic logic [12:0] ref_word(input logic [5:0] op);
      logic [1:0] grp;
      logic [4:0] alu;
      logic [1:0] imm, m2r;
      logic       mw, rw, pc, asrc;
      if (!is_legal(op)) return 13'd0;
      grp  = op[5:4];
      alu  = {grp, op[2:0]};
      imm  = (op[3] || grp == 2'b10 || grp == 2'b11) ? grp : 2'b00;
      asrc = op[3] || grp == 2'b10 || grp == 2'b11;
      m2r  = (op == 6'o04 || op == 6'o14) ? 2'b10 : (op == 6'o51) ? 2'b01 : 2'b00;
      mw   = (op == 6'o53);
      rw   = (grp == 2'b00 && op != 6'o00) || grp == 2'b01 || op == 6'o51 || op == 6'o52;
      pc   = (grp == 2'b11);
      return {alu, imm, m2r, mw, rw, pc, asrc};
   endfunction

   function automatic logic [12:0] dut_word();
      return {bus.alu_control, bus.imm_src, bus.mem_to_reg,
              bus.mem_write, bus.reg_write, bus.pc_src, bus.alu_src};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare DUT with the model, advance the model.
   task automatic step(input logic r, input logic f, input logic iv,
                       input logic [5:0] op, input logic ordy);
      logic        exp_ready;
      logic        n_valid, n_illegal;
      logic [12:0] n_word, n_pend;
      int          n_busy;
      @(negedge clk);
      rst = r; flush = f;
      bus.in_valid = iv; bus.opcode = op; bus.out_ready = ordy;
      #1;
      exp_ready = !r && !f && (m_busy == 0) && (!m_valid || ordy);
      check("in_ready",  32'(bus.in_ready), 32'(exp_ready));
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("ctrl_word", 32'(dut_word()), 32'(m_word));
`ifdef PCU_ILLEGAL_TRAP_EN
      check("illegal",   32'(bus.illegal), 32'(m_illegal));
`endif
      n_valid = m_valid; n_word = m_word; n_busy = m_busy;
      n_pend = m_pend; n_illegal = m_illegal;
      if (r || f) begin
         n_valid = 0; n_word = 0; n_busy = 0; n_illegal = 0;
         if (r) n_pend = 0;
      end else if (m_busy > 0) begin
         n_busy = m_busy - 1;
         if (n_busy == 0) begin
            n_valid = 1; n_word = m_pend;
         end
      end else if (iv && exp_ready) begin
         n_illegal = !is_legal(op);
         if (is_legal(op) && op[5:4] == 2'b00 && op[2:0] == 3'b011 && MUL_CYCLES > 1) begin
            n_busy = MUL_CYCLES; n_pend = ref_word(op);
            n_valid = 0; n_word = 0;
         end else begin
            n_valid = 1; n_word = ref_word(op);
         end
      end else if (m_valid && ordy) begin
         n_valid = 0; n_word = 0;
      end
      @(posedge clk);
      #1;
      m_valid = n_valid; m_word = n_word; m_busy = n_busy;
      m_pend = n_pend; m_illegal = n_illegal;
   endtask

   initial begin
      logic [5:0] rop;
      m_valid = 0; m_word = 0; m_busy = 0; m_pend = 0; m_illegal = 0;
      rst = 1; flush = 0;
      bus.in_valid = 0; bus.opcode = 0; bus.out_ready = 1;

      // Reset state
      step(1, 0, 1, 6'o01, 1);
      step(1, 0, 1, 6'o01, 1);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_in_ready",  32'(bus.in_ready), 0);
      check("rst_word",      32'(dut_word()), 0);

      // ADD, one-cycle latency
      step(0, 0, 1, 6'o01, 1);
      check("add_valid",  32'(bus.out_valid), 1);
      check("add_alu",    32'(bus.alu_control), 32'h01);
      check("add_rw",     32'(bus.reg_write), 1);
      check("add_asrc",   32'(bus.alu_src), 0);
      check("add_m2r",    32'(bus.mem_to_reg), 0);

      // MULI with MUL_CYCLES=3 (old ADD word drains at acceptance)
      step(0, 0, 1, 6'o13, 1);
      check("muli_busy0", 32'(bus.in_ready), 0);
      check("muli_nv0",   32'(bus.out_valid), 0);
      step(0, 0, 1, 6'o01, 1);
      check("muli_busy1", 32'(bus.in_ready), 0);
      step(0, 0, 1, 6'o01, 1);
      check("muli_busy2", 32'(bus.in_ready), 0);
      check("muli_nv2",   32'(bus.out_valid), 0);
      step(0, 0, 0, 6'o00, 0);
      check("muli_valid", 32'(bus.out_valid), 1);
      check("muli_alu",   32'(bus.alu_control), 32'h03);
      check("muli_asrc",  32'(bus.alu_src), 1);
      check("muli_imm",   32'(bus.imm_src), 0);

      // STR held under back-pressure, then replaced without a bubble
      step(0, 0, 0, 6'o00, 1);
      step(0, 0, 1, 6'o53, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 6'o01, 0);
         check("str_valid", 32'(bus.out_valid), 1);
         check("str_mw",    32'(bus.mem_write), 1);
         check("str_rw",    32'(bus.reg_write), 0);
         check("str_asrc",  32'(bus.alu_src), 1);
         check("str_ready", 32'(bus.in_ready), 0);
      end
      step(0, 0, 1, 6'o01, 1);
      check("swap_valid", 32'(bus.out_valid), 1);
      check("swap_alu",   32'(bus.alu_control), 32'h01);

      // JEQ then flush
      step(0, 0, 1, 6'o71, 1);
      check("jeq_pc", 32'(bus.pc_src), 1);
      step(0, 1, 1, 6'o01, 1);
      check("flush_valid", 32'(bus.out_valid), 0);
      check("flush_word",  32'(dut_word()), 0);
      check("flush_ready", 32'(bus.in_ready), 0);
      step(0, 0, 0, 6'o00, 1);
      check("post_flush_ready", 32'(bus.in_ready), 1);

      // Flush and reset abandon a multiply
      step(0, 0, 1, 6'o03, 1);
      step(0, 1, 0, 6'o00, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 6'o00, 0);
         check("mul_flushed", 32'(bus.out_valid), 0);
      end
      step(0, 0, 1, 6'o03, 1);
      step(1, 0, 0, 6'o00, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 6'o00, 0);
         check("mul_reset", 32'(bus.out_valid), 0);
      end

`ifdef PCU_ILLEGAL_TRAP_EN
      step(0, 0, 1, 6'o07, 1);
      check("ill_valid", 32'(bus.out_valid), 1);
      check("ill_word",  32'(dut_word()), 0);
      check("ill_flag",  32'(bus.illegal), 1);
      step(0, 0, 1, 6'o51, 1);
      check("ldr_m2r",   32'(bus.mem_to_reg), 1);
      check("ldr_imm",   32'(bus.imm_src), 2);
      check("ldr_ill",   32'(bus.illegal), 0);
`else
      step(0, 0, 1, 6'o07, 1);
      check("undef_valid", 32'(bus.out_valid), 1);
      check("undef_word",  32'(dut_word()), 0);
`endif

      // Streaming ORI, XOR, MOVI
      step(0, 0, 1, 6'o32, 1);
      check("ori_alu",  32'(bus.alu_control), 32'h0A);
      step(0, 0, 1, 6'o23, 1);
      check("xor_alu",  32'(bus.alu_control), 32'h0B);
      check("xor_valid", 32'(bus.out_valid), 1);
      step(0, 0, 1, 6'o14, 1);
      check("movi_alu", 32'(bus.alu_control), 32'h04);
      check("movi_m2r", 32'(bus.mem_to_reg), 2);
      check("movi_valid", 32'(bus.out_valid), 1);
      step(0, 0, 0, 6'o00, 1);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 75) rop = LEGAL[$urandom_range(0, 24)];
         else                            rop = 6'($urandom);
         step($urandom_range(0, 199) < 1, $urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < 70, rop, $urandom_range(0, 99) < 70);
      end
      step(0, 0, 0, 6'o00, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
